// File: rtl/int_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_req_ctrl
// Description : Interrupt request controller for the MINT redirect stage.
//               It edge-detects three IRQ lines and latches them as pending.
//               It issues a one-cycle take pulse with a 2-bit code, gated by
//               the global enable, pipeline hold, a holdoff window and nested
//               priority. An in-service level stack is popped on eret.
// Revision    : 1.0 - initial release
// ============================================================================
module int_req_ctrl #(
  parameter int HOLDOFF = 2
) (
  input  logic       in_CLK,
  input  logic       in_RST,
  input  logic [2:0] in_IRQ,
  input  logic       in_IE,
  input  logic       in_hold,
  input  logic       in_eret,
  input  logic [3:0] in_IG,
  output logic       out_BK,
  output logic [1:0] out_code,
  output logic [2:0] out_pending,
  output logic [1:0] out_level,
  output logic [1:0] out_depth
);

  // Holdoff counter width; at least one bit even when HOLDOFF is zero.
  localparam int c_HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [c_HW-1:0] c_HOLDOFF = c_HW'(HOLDOFF);

  logic [2:0]      r_prev;
  logic [2:0]      r_pending;
  logic [1:0]      r_level;
  logic [1:0]      r_depth;
  logic [1:0]      r_stack [0:2];
  logic            r_bk;
  logic [1:0]      r_code;
  logic [c_HW-1:0] r_hold_cnt;

  logic [2:0] w_edge;
  logic [1:0] w_cand;
  logic [1:0] w_top;
  logic       w_take;
  logic       w_pop;
  logic       w_unused;

  // MINT drives a 4-bit grant vector; bit 3 has no source behind it.
  assign w_unused = in_IG[3];

  // Rising edges relative to the previous sample.
  assign w_edge = in_IRQ & ~r_prev;

  // Highest pending source wins: 3 > 2 > 1.
  always_comb begin
    w_cand = 2'd0;
    if (r_pending[2])      w_cand = 2'd3;
    else if (r_pending[1]) w_cand = 2'd2;
    else if (r_pending[0]) w_cand = 2'd1;
  end

  // Saved level at the top of the in-service stack.
  always_comb begin
    w_top = 2'd0;
    case (r_depth)
      2'd1:    w_top = r_stack[0];
      2'd2:    w_top = r_stack[1];
      2'd3:    w_top = r_stack[2];
      default: w_top = 2'd0;
    endcase
  end

  // Eret and take are mutually exclusive because eret blocks a take.
  assign w_take = (w_cand > r_level) & in_IE & ~in_hold & ~in_eret
                & (r_hold_cnt == '0) & ~r_bk;
  assign w_pop  = in_eret & (r_depth != 2'd0);

  // Edge detection and pending latch; a new edge beats a same-cycle clear.
  always_ff @(posedge in_CLK) begin
    if (!in_RST) begin
      r_prev    <= 3'b111;
      r_pending <= 3'b000;
    end else begin
      r_prev    <= in_IRQ;
      r_pending <= w_edge | (r_pending & ~in_IG[2:0]);
    end
  end

  // Take pulse, code register and holdoff window after each take.
  always_ff @(posedge in_CLK) begin
    if (!in_RST) begin
      r_bk       <= 1'b0;
      r_code     <= 2'd0;
      r_hold_cnt <= '0;
    end else if (w_take) begin
      r_bk       <= 1'b1;
      r_code     <= w_cand;
      r_hold_cnt <= c_HOLDOFF;
    end else begin
      r_bk <= 1'b0;
      if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  // In-service level stack: push current level on take, restore on eret.
  always_ff @(posedge in_CLK) begin
    if (!in_RST) begin
      r_level <= 2'd0;
      r_depth <= 2'd0;
      for (int i = 0; i < 3; i++) r_stack[i] <= 2'd0;
    end else if (w_take) begin
      for (int i = 0; i < 3; i++) begin
        if (r_depth == i[1:0]) r_stack[i] <= r_level;
      end
      r_level <= w_cand;
      r_depth <= r_depth + 2'd1;
    end else if (w_pop) begin
      r_level <= w_top;
      r_depth <= r_depth - 2'd1;
    end
  end

  // Strictly increasing nesting bounds the stack at three entries.
  a_no_overflow: assert property (@(posedge in_CLK) disable iff (!in_RST)
    !(w_take && (r_depth == 2'd3)));

  assign out_BK      = r_bk;
  assign out_code    = r_code;
  assign out_pending = r_pending;
  assign out_level   = r_level;
  assign out_depth   = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_int_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_req_ctrl
// Description : Self-checking bench for int_req_ctrl. Directed scenarios and
//               randomized traffic, compared against a behavioural model that
//               tracks in-service priorities as a queue and holdoff by cycle
//               number.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_req_ctrl;

  localparam int HOLDOFF = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] irq;
  logic       ie, hold, eret;
  logic [3:0] ig;
  logic       bk;
  logic [1:0] code;
  logic [2:0] pending;
  logic [1:0] level, depth;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [2:0] m_prev;
  logic [2:0] m_pend;
  logic       m_bk;
  logic [1:0] m_code;
  int         m_q[$];
  int         m_n;
  int         m_last;

  always #5 clk = ~clk;

  int_req_ctrl #(.HOLDOFF(HOLDOFF)) dut (
    .in_CLK      (clk),
    .in_RST      (rst_n),
    .in_IRQ      (irq),
    .in_IE       (ie),
    .in_hold     (hold),
    .in_eret     (eret),
    .in_IG       (ig),
    .out_BK      (bk),
    .out_code    (code),
    .out_pending (pending),
    .out_level   (level),
    .out_depth   (depth)
  );

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_level();
    return (m_q.size() > 0) ? m_q[$] : 0;
  endfunction

  // One clock edge of the model, from the same inputs the DUT samples.
  task automatic model_step();
    int cand;
    logic [2:0] edges;
    bit ok;
    m_n++;
    if (!rst_n) begin
      m_prev = 3'b111;
      m_pend = 3'b000;
      m_bk   = 1'b0;
      m_code = 2'd0;
      m_q.delete();
      m_last = -1000;
      return;
    end
    edges = irq & ~m_prev;
    cand  = 0;
    for (int i = 0; i < 3; i++) if (m_pend[i]) cand = i + 1;
    ok = (cand > m_level()) && ie && !hold && !eret && !m_bk
         && (m_n - m_last >= HOLDOFF + 1);
    m_pend = edges | (m_pend & ~ig[2:0]);
    if (ok) begin
      m_bk   = 1'b1;
      m_code = 2'(cand);
      m_q.push_back(cand);
      m_last = m_n;
    end else begin
      m_bk = 1'b0;
    end
    if (eret && m_q.size() > 0) void'(m_q.pop_back());
    m_prev = irq;
  endtask

  // Advance one cycle, then compare all outputs against the model.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("bk",      int'(bk),      int'(m_bk));
    check("code",    int'(code),    int'(m_code));
    check("pending", int'(pending), int'(m_pend));
    check("level",   int'(level),   m_level());
    check("depth",   int'(depth),   m_q.size());
  endtask

  task automatic drive(input logic [2:0] i_irq, input logic i_ie,
                       input logic i_hold, input logic i_eret,
                       input logic [3:0] i_ig);
    irq  = i_irq;
    ie   = i_ie;
    hold = i_hold;
    eret = i_eret;
    ig   = i_ig;
  endtask

  initial begin
    int gap;
    m_n = 0; m_last = -1000; m_prev = 3'b111; m_pend = 0; m_bk = 0; m_code = 0;

    // Reset with all lines high; they must not request afterwards.
    rst_n = 1'b0;
    drive(3'b111, 1'b1, 1'b0, 1'b0, 4'b0000);
    repeat (3) cyc();
    check("rst_pending", int'(pending), 0);
    check("rst_level",   int'(level),   0);
    rst_n = 1'b1;
    repeat (2) cyc();
    check("held_irq_no_pending", int'(pending), 0);
    drive(3'b000, 1'b1, 1'b0, 1'b0, 4'b0000);
    cyc();

    // Single request on source 2.
    irq = 3'b010;
    cyc();
    check("single_pending", int'(pending), 3'b010);
    check("single_bk_early", int'(bk), 0);
    cyc();
    check("single_bk",    int'(bk),    1);
    check("single_code",  int'(code),  2);
    check("single_level", int'(level), 2);
    check("single_depth", int'(depth), 1);
    cyc();
    check("single_bk_one", int'(bk), 0);

    // Nested preempt by source 3; source 1 then stays pending.
    irq = 3'b110;
    repeat (2) cyc();
    check("nest_bk",    int'(bk),    1);
    check("nest_code",  int'(code),  3);
    check("nest_depth", int'(depth), 2);
    irq = 3'b111;
    repeat (4) cyc();
    check("low_pri_no_bk",   int'(bk),      0);
    check("low_pri_pending", int'(pending), 3'b111);

    // Unwind both levels, clearing pending via the grant vector.
    drive(3'b111, 1'b1, 1'b0, 1'b1, 4'b0100);
    cyc();
    check("unwind1_level",   int'(level),   2);
    check("unwind1_pending", int'(pending), 3'b011);
    drive(3'b111, 1'b1, 1'b0, 1'b1, 4'b0010);
    cyc();
    check("unwind2_level",   int'(level),   0);
    drive(3'b111, 1'b1, 1'b0, 1'b0, 4'b0000);
    cyc();
    check("src1_bk",   int'(bk),   1);
    check("src1_code", int'(code), 1);
    drive(3'b111, 1'b1, 1'b0, 1'b1, 4'b0001);
    cyc();
    drive(3'b111, 1'b1, 1'b0, 1'b1, 4'b0000);
    cyc();
    check("eret_d0_level", int'(level), 0);
    check("eret_d0_depth", int'(depth), 0);

    // Gating by IE=0, then by hold; requests survive.
    drive(3'b000, 1'b0, 1'b0, 1'b0, 4'b0000);
    cyc();
    irq = 3'b100;
    repeat (6) cyc();
    check("ie_gate_bk", int'(bk), 0);
    ie = 1'b1;
    cyc();
    check("ie_release_bk",   int'(bk),   1);
    check("ie_release_code", int'(code), 3);
    drive(3'b000, 1'b1, 1'b1, 1'b1, 4'b0100);
    cyc();
    drive(3'b100, 1'b1, 1'b1, 1'b0, 4'b0000);
    repeat (5) cyc();
    check("hold_gate_bk", int'(bk), 0);
    hold = 1'b0;
    cyc();
    check("hold_release_bk",   int'(bk),   1);
    check("hold_release_code", int'(code), 3);
    drive(3'b000, 1'b1, 1'b0, 1'b1, 4'b0100);
    cyc();

    // Set and clear of the same bit in one cycle: set wins.
    drive(3'b000, 1'b0, 1'b0, 1'b0, 4'b0000);
    cyc();
    drive(3'b001, 1'b0, 1'b0, 1'b0, 4'b0001);
    cyc();
    check("set_wins", int'(pending[0]), 1);
    ig = 4'b0001;
    cyc();
    check("clear_after", int'(pending[0]), 0);

    // Holdoff: source 1 taken, source 2 arrives right after.
    drive(3'b000, 1'b1, 1'b0, 1'b0, 4'b0000);
    repeat (4) cyc();
    irq = 3'b001;
    cyc();
    cyc();
    check("hoff_first", int'(bk), 1);
    irq = 3'b011;
    gap = 0;
    do begin
      cyc();
      gap++;
    end while (!bk && gap < 12);
    check("hoff_gap",  gap,        3);
    check("hoff_code", int'(code), 2);

    // Reset mid-service clears everything.
    rst_n = 1'b0;
    cyc();
    check("midrst_bk",      int'(bk),      0);
    check("midrst_code",    int'(code),    0);
    check("midrst_pending", int'(pending), 0);
    check("midrst_level",   int'(level),   0);
    check("midrst_depth",   int'(depth),   0);
    rst_n = 1'b1;
    drive(3'b000, 1'b1, 1'b0, 1'b0, 4'b0000);
    cyc();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
      ie    = ($urandom_range(0, 7) != 0);
      hold  = ($urandom_range(0, 5) == 0);
      eret  = ($urandom_range(0, 6) == 0);
      ig    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      rst_n = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/int_req_ctrl.md
# int_req_ctrl

Interrupt request controller sitting directly upstream of the interrupt/eret redirect stage (MINT). It edge-detects three external interrupt lines, latches them as pending, and applies the global enable, a pipeline hold and nested priority against an in-service level stack. It issues a one-cycle take pulse with a 2-bit code to MINT, and clears pending bits from MINT's `out_IG` grant vector on eret.

## Interface
- `HOLDOFF`, default 2: cycles after a take during which no further take is issued (pipeline flush window).
- `in_CLK`  in  1  clock; all state updates on rising edge.
- `in_RST`  in  1  synchronous, active-low reset.
- `in_IRQ`  in  3  raw interrupt lines; bit i = source i+1; rising edge requests.
- `in_IE`  in  1  global interrupt enable (status register).
- `in_hold`  in  1  pipeline cannot accept a redirect this cycle; suppresses take.
- `in_eret`  in  1  eret retiring this cycle (same pulse MINT sees).
- `in_IG`  in  4  pending-clear vector from MINT `out_IG`; bit0/1/2 clear source 1/2/3; bit3 ignored.
- `out_BK`  out  1  take-interrupt pulse, one cycle, to MINT `in_BK`.
- `out_code`  out  2  code of taken source (1..3), valid while `out_BK`=1, holds last value otherwise.
- `out_pending`  out  3  current pending register.
- `out_level`  out  2  in-service priority level (0 = none, 3 = highest).
- `out_depth`  out  2  in-service stack occupancy 0..3.

## Operation
- Reset (`in_RST`=0 at edge): pending=0, level=0, stack entries=0, depth=0, `out_BK`=0, `out_code`=0, holdoff counter=0, prev-IRQ register=3'b111, so lines held high through reset do not request.
- Edge detect: edge[i] = `in_IRQ`[i] & ~prev[i]; prev <= `in_IRQ` every cycle.
- Pending update per bit: pending[i] <= edge[i] | (pending[i] & ~`in_IG`[i]). Set wins over simultaneous clear.
- Priority: source 3 > 2 > 1. cand = highest pending index+1, 0 if none.
- Eligible = cand > level & `in_IE` & ~`in_hold` & ~`in_eret` & holdoff counter == 0 & ~`out_BK`.
- Take (eligible at edge): `out_BK`<=1, `out_code`<=cand, push level onto stack, level<=cand, depth+=1, holdoff counter<=`HOLDOFF`. Pending is NOT cleared on take; it is cleared only by `in_IG`.
- Otherwise `out_BK`<=0; holdoff counter decrements to 0 and saturates.
- Eret (`in_eret`=1): level<=top of stack, pop, depth-=1. With depth=0: ignored, level stays 0.
- Nesting is strictly increasing, so depth never exceeds 3; no overflow path is required. A push with depth=3 must never occur (assertion).
- Equal or lower priority requests stay pending until level drops below them.

## Timing
- Edge E0 samples rising `in_IRQ`[i]: pending[i]=1 is visible after E0.
- Earliest take: edge E1 → `out_BK`=1 during cycle after E1 (2-cycle latency line→`out_BK`).
- `out_BK` is high for exactly one cycle. With `HOLDOFF`=2, the earliest next `out_BK` is 3 cycles after the previous one.
- Eret at edge Ek: level updated after Ek; a take is blocked at Ek and may occur at Ek+1.
- `in_IG` clear at edge Ek: pending bit 0 after Ek unless a new edge arrives at Ek.
- `in_hold` or `in_IE`=0 only delays a take; requests are never lost.
- Reset mid-service: all state cleared on the reset edge; a pulse in flight is dropped.

## Test plan
- Single request: `in_IE`=1, raise `in_IRQ`[1] at E0 → pending=3'b010 after E0, `out_BK`=1 & `out_code`=2 for one cycle after E1, level=2, depth=1.
- Nested preempt: in service at level 2, raise `in_IRQ`[2] → take code 3, depth=2. Raise `in_IRQ`[0] → stays pending, no `out_BK`.
- Unwind: from depth 2 (levels 0→2→3), eret with `in_IG`=4'b0100 → level=2, pending[2]=0. Second eret with `in_IG`=4'b0010 → level=0. Pending source 1 then taken (code 1) on the following eligible edge.
- Gating: pending code 3 with `in_IE`=0 or `in_hold`=1 for 5 cycles → no `out_BK`. Release → `out_BK` on the next edge with `out_code`=3.
- Boundaries: simultaneous edge and `in_IG` clear on the same bit → bit stays 1. Eret at depth 0 → level 0, depth 0. `in_IRQ`=3'b111 held through reset → no pending after reset.
- Holdoff and reset: two pending sources of rising priority → second take no earlier than 3 cycles after first. Assert `in_RST`=0 mid-service → all outputs 0 next cycle.
